// File: rtl/vp_issue_pkg.sv
// Shared types for the issue sequencer: instruction layout, decode result, scoreboard entry.
package vp_issue_pkg;

  localparam int unsigned INSTN_W  = 32;
  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned CNT_W    = 16;

  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 6'h00;
  localparam logic [INSTN_W-1:0]  NOP_INSTN = 32'h0;

  typedef logic [REG_AW-1:0] reg_addr_t;

  // Field positions: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]
  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    reg_addr_t           rs;
    reg_addr_t           rt;
    reg_addr_t           rd;
    logic [4:0]          shamt;
    logic [5:0]          funct;
  } instn_t;

  typedef struct packed {
    logic      src0_v;
    reg_addr_t src0;
    logic      src1_v;
    reg_addr_t src1;
    logic      dst_v;
    reg_addr_t dst;
  } dec_t;

  typedef struct packed {
    logic      v;
    reg_addr_t addr;
  } sb_entry_t;

  // R-type reads rs/rt and writes rd; everything else reads rs and writes rt. r0 never counts.
  function automatic dec_t decode(input logic [OPCODE_W-1:0] op, input reg_addr_t rs,
                                  input reg_addr_t rt, input reg_addr_t rd);
    dec_t d;
    logic rtype;
    rtype    = (op == OP_RTYPE);
    d.src0   = rs;
    d.src0_v = (rs != '0);
    d.src1   = rt;
    d.src1_v = rtype && (rt != '0);
    d.dst    = rtype ? rd : rt;
    d.dst_v  = (d.dst != '0);
    return d;
  endfunction

endpackage

// File: rtl/vp_issue_ctrl_if.sv
// Upstream instruction handshake, overflow control and pipeline-facing outputs of vp_issue_ctrl.
interface vp_issue_ctrl_if;
  import vp_issue_pkg::*;

  logic             in_valid;
  instn_t           in_instn;
  logic             in_ready;
  logic             alu_overflow;
  logic             ovf_clear;
  instn_t           instn;
  logic             issue_valid;
  logic             halted;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, in_instn, alu_overflow, ovf_clear,
    input  in_ready, instn, issue_valid, halted, issue_cnt, stall_cnt
  );

  modport slave (
    input  in_valid, in_instn, alu_overflow, ovf_clear,
    output in_ready, instn, issue_valid, halted, issue_cnt, stall_cnt
  );
endinterface

// File: rtl/vp_issue_fifo.sv
// Instruction FIFO, DEPTH x WIDTH; push is refused when full even if a pop happens that cycle.
module vp_issue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_full_c,
  output logic             o_empty_c,
  output logic [WIDTH-1:0] o_head_c
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full_c  = (r_count == OCC_W'(DEPTH));
  assign o_empty_c = (r_count == '0);
  assign o_head_c  = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full_c;
  assign w_pop_ok  = i_pop & ~o_empty_c;

  // Storage carries no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vp_issue_ctrl.sv
// Issue sequencer: FIFO-buffered instructions, RAW scoreboard with NOP bubbles, issue/stall counters.
// Optional overflow halt enabled by defining VP_OVF_HALT_EN.
module vp_issue_ctrl
  import vp_issue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WB_LAT = 2
) (
  input logic           clk,
  input logic           rst_n,
  vp_issue_ctrl_if.slave bus
);

  // A result issued at edge t is readable at edge t+WB_LAT, so it blocks dependants for WB_LAT-1 cycles.
  localparam int unsigned SB_DEPTH = (WB_LAT > 1) ? WB_LAT - 1 : 1;

  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_issue;
  logic               w_hazard;
  logic               w_halted;
  logic [INSTN_W-1:0] w_fifo_head;
  instn_t             w_head;
  dec_t               w_dec;
  sb_entry_t          w_sb_in;

  sb_entry_t          r_sb [SB_DEPTH];
  instn_t             r_instn;
  logic               r_issue_valid;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic [CNT_W-1:0]   r_stall_cnt;

  assign w_push = bus.in_valid & ~w_full;

  vp_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTN_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_data    (bus.in_instn),
    .i_pop     (w_issue),
    .o_full_c  (w_full),
    .o_empty_c (w_empty),
    .o_head_c  (w_fifo_head)
  );

  assign w_head = instn_t'(w_fifo_head);
  assign w_dec  = decode(w_head.opcode, w_head.rs, w_head.rt, w_head.rd);

  // RAW check of the head's sources against every in-flight destination
  always_comb begin
    w_hazard = 1'b0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if ((WB_LAT > 1) && r_sb[i].v &&
          ((w_dec.src0_v && (r_sb[i].addr == w_dec.src0)) ||
           (w_dec.src1_v && (r_sb[i].addr == w_dec.src1)))) begin
        w_hazard = 1'b1;
      end
    end
  end

  assign w_issue = ~w_empty & ~w_hazard & ~w_halted;

  always_comb begin
    w_sb_in = '0;
    if (w_issue) begin
      w_sb_in.v    = w_dec.dst_v;
      w_sb_in.addr = w_dec.dst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SB_DEPTH; i++) r_sb[i] <= '0;
    end else begin
      r_sb[0] <= w_sb_in;
      for (int unsigned i = 1; i < SB_DEPTH; i++) r_sb[i] <= r_sb[i-1];
    end
  end

  // Pipeline-facing instruction register and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instn       <= instn_t'(NOP_INSTN);
      r_issue_valid <= 1'b0;
      r_issue_cnt   <= '0;
      r_stall_cnt   <= '0;
    end else if (w_issue) begin
      r_instn       <= w_head;
      r_issue_valid <= 1'b1;
      r_issue_cnt   <= r_issue_cnt + CNT_W'(1);
    end else begin
      r_instn       <= instn_t'(NOP_INSTN);
      r_issue_valid <= 1'b0;
      if (!w_empty && w_hazard && !w_halted) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

`ifdef VP_OVF_HALT_EN
  logic r_halted;

  // Clear has priority over a coincident overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_halted <= 1'b0;
    else if (bus.ovf_clear)    r_halted <= 1'b0;
    else if (bus.alu_overflow) r_halted <= 1'b1;
  end

  assign w_halted = r_halted;
`else
  logic w_unused_ovf;

  assign w_unused_ovf = bus.alu_overflow ^ bus.ovf_clear;
  assign w_halted     = 1'b0;
`endif

  assign bus.in_ready    = ~w_full;
  assign bus.instn       = r_instn;
  assign bus.issue_valid = r_issue_valid;
  assign bus.halted      = w_halted;
  assign bus.issue_cnt   = r_issue_cnt;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_vp_issue_ctrl.sv
// Directed bench for vp_issue_ctrl (DEPTH=4, WB_LAT=2): vector tables plus full-FIFO and mid-run reset sequences.
module tb_vp_issue_ctrl;
  import vp_issue_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  vp_issue_ctrl_if u_if ();

  vp_issue_ctrl #(
    .DEPTH  (4),
    .WB_LAT (2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic [31:0] in_instn;
    logic        alu_ovf;
    logic        ovf_clr;
    logic        exp_ready;
    logic [31:0] exp_instn;
    logic        exp_valid;
    logic        exp_halted;
    logic [15:0] exp_issue;
    logic [15:0] exp_stall;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [31:0] rt_add(input int rd, input int rs, input int rt);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'h20};
  endfunction

  function automatic logic [31:0] it_op(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic vec_t mk(input int iv, input logic [31:0] ii, input int ao, input int oc,
                              input int rdy, input logic [31:0] ei, input int ev, input int eh,
                              input int iss, input int stl);
    vec_t v;
    v.in_valid   = 1'(iv);
    v.in_instn   = ii;
    v.alu_ovf    = 1'(ao);
    v.ovf_clr    = 1'(oc);
    v.exp_ready  = 1'(rdy);
    v.exp_instn  = ei;
    v.exp_valid  = 1'(ev);
    v.exp_halted = 1'(eh);
    v.exp_issue  = 16'(iss);
    v.exp_stall  = 16'(stl);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".in_ready"},    32'(u_if.in_ready),    32'(v.exp_ready));
    check({tag, ".instn"},       u_if.instn,            v.exp_instn);
    check({tag, ".issue_valid"}, 32'(u_if.issue_valid), 32'(v.exp_valid));
    check({tag, ".halted"},      32'(u_if.halted),      32'(v.exp_halted));
    check({tag, ".issue_cnt"},   32'(u_if.issue_cnt),   32'(v.exp_issue));
    check({tag, ".stall_cnt"},   32'(u_if.stall_cnt),   32'(v.exp_stall));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    u_if.in_valid     = v.in_valid;
    u_if.in_instn     = v.in_instn;
    u_if.alu_overflow = v.alu_ovf;
    u_if.ovf_clear    = v.ovf_clr;
    @(posedge clk);
    #1;
    check_outputs(tag, v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    vec_t        tbl6[$];
    logic [31:0] x[1:9];
    logic [31:0] y[8];
    logic [31:0] z1, z2;
    logic [31:0] got[$];
    logic        exp_rdy[8];
    logic [31:0] g;
    int          pushed;
    bit          acc;

    u_if.in_valid     = 1'b0;
    u_if.in_instn     = '0;
    u_if.alu_overflow = 1'b0;
    u_if.ovf_clear    = 1'b0;

    // Power-on reset
    #2 rst_n = 1'b0;
    #1 check_outputs("reset", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    x[1] = rt_add(1, 2, 3);
    x[2] = rt_add(4, 5, 6);
    x[3] = rt_add(1, 2, 3);
    x[4] = rt_add(4, 1, 5);
    x[5] = rt_add(0, 2, 3);
    x[6] = rt_add(4, 0, 0);
    x[7] = it_op(6'h23, 2, 7, 16'h0010);
    x[8] = rt_add(8, 7, 9);
    x[9] = it_op(6'h08, 3, 8, 16'h0004);

    // in_valid, in_instn, ovf, clr | ready, instn, valid, halted, issue_cnt, stall_cnt
    tbl.push_back(mk(1, x[1], 0, 0, 1, 0,    0, 0, 0, 0));
    tbl.push_back(mk(1, x[2], 0, 0, 1, x[1], 1, 0, 1, 0));
    tbl.push_back(mk(0, 0,    0, 0, 1, x[2], 1, 0, 2, 0));
    tbl.push_back(mk(0, 0,    0, 0, 1, 0,    0, 0, 2, 0));
    tbl.push_back(mk(1, x[3], 0, 0, 1, 0,    0, 0, 2, 0));
    tbl.push_back(mk(1, x[4], 0, 0, 1, x[3], 1, 0, 3, 0));
    tbl.push_back(mk(0, 0,    0, 0, 1, 0,    0, 0, 3, 1));
    tbl.push_back(mk(0, 0,    0, 0, 1, x[4], 1, 0, 4, 1));
    tbl.push_back(mk(0, 0,    0, 0, 1, 0,    0, 0, 4, 1));
    tbl.push_back(mk(1, x[5], 0, 0, 1, 0,    0, 0, 4, 1));
    tbl.push_back(mk(1, x[6], 0, 0, 1, x[5], 1, 0, 5, 1));
    tbl.push_back(mk(0, 0,    0, 0, 1, x[6], 1, 0, 6, 1));
    tbl.push_back(mk(0, 0,    0, 0, 1, 0,    0, 0, 6, 1));
    tbl.push_back(mk(1, x[7], 0, 0, 1, 0,    0, 0, 6, 1));
    tbl.push_back(mk(1, x[8], 0, 0, 1, x[7], 1, 0, 7, 1));
    tbl.push_back(mk(1, x[9], 0, 0, 1, 0,    0, 0, 7, 2));
    tbl.push_back(mk(0, 0,    0, 0, 1, x[8], 1, 0, 8, 2));
    tbl.push_back(mk(0, 0,    0, 0, 1, x[9], 1, 0, 9, 2));
    tbl.push_back(mk(0, 0,    0, 0, 1, 0,    0, 0, 9, 2));

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("main[%0d]", i));

    // Full FIFO: a rt-dependency chain stalls every other cycle while pushes arrive each cycle
    for (int k = 0; k < 8; k++) y[k] = rt_add(10 + k, 0, 9 + k);
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    pushed  = 0;
    for (int cyc = 1; cyc <= 60 && got.size() < 8; cyc++) begin
      u_if.in_valid = (pushed < 8);
      u_if.in_instn = (pushed < 8) ? y[pushed] : 32'h0;
      acc           = (pushed < 8) && u_if.in_ready;
      @(posedge clk);
      #1;
      if (acc) pushed++;
      if (u_if.issue_valid) got.push_back(u_if.instn);
      if (cyc <= 8) check($sformatf("full.in_ready[%0d]", cyc), 32'(u_if.in_ready), 32'(exp_rdy[cyc-1]));
      if (cyc == 8) check("full.push_refused", 32'(pushed), 32'd7);
    end
    u_if.in_valid = 1'b0;
    check("full.drain_count", 32'(got.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      g = (k < got.size()) ? got[k] : 32'hDEAD_BEEF;
      check($sformatf("full.order[%0d]", k), g, y[k]);
    end
    check("full.issue_cnt", 32'(u_if.issue_cnt), 32'd17);
    check("full.stall_cnt", 32'(u_if.stall_cnt), 32'd9);

    // Mid-run asynchronous reset with two instructions still buffered
    for (int k = 0; k < 3; k++) begin
      u_if.in_valid = 1'b1;
      u_if.in_instn = y[k];
      @(posedge clk);
    end
    u_if.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_outputs("midreset", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "post_reset[0]");
    run_vec(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "post_reset[1]");

    // Overflow halt behaviour
    z1 = rt_add(20, 21, 22);
    z2 = rt_add(23, 24, 25);
`ifdef VP_OVF_HALT_EN
    tbl6.push_back(mk(1, z1, 1, 0, 1, 0,  0, 1, 0, 0));
    tbl6.push_back(mk(1, z2, 0, 0, 1, 0,  0, 1, 0, 0));
    tbl6.push_back(mk(0, 0,  0, 0, 1, 0,  0, 1, 0, 0));
    tbl6.push_back(mk(0, 0,  1, 1, 1, 0,  0, 0, 0, 0));
    tbl6.push_back(mk(0, 0,  0, 0, 1, z1, 1, 0, 1, 0));
    tbl6.push_back(mk(0, 0,  0, 0, 1, z2, 1, 0, 2, 0));
    tbl6.push_back(mk(0, 0,  0, 0, 1, 0,  0, 0, 2, 0));
`else
    tbl6.push_back(mk(1, z1, 1, 0, 1, 0,  0, 0, 0, 0));
    tbl6.push_back(mk(1, z2, 0, 0, 1, z1, 1, 0, 1, 0));
    tbl6.push_back(mk(0, 0,  0, 1, 1, z2, 1, 0, 2, 0));
    tbl6.push_back(mk(0, 0,  1, 0, 1, 0,  0, 0, 2, 0));
    tbl6.push_back(mk(0, 0,  0, 0, 1, 0,  0, 0, 2, 0));
`endif
    foreach (tbl6[i]) run_vec(tbl6[i], $sformatf("ovf[%0d]", i));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
